// File: rtl/sample_proc_pkg.sv
// Shared definitions for the sample processor: operating modes and a
// width-generic saturation helper.
package sample_proc_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_GAIN = 2'd1,
    MODE_AVG  = 2'd2,
    MODE_INV  = 2'd3
  } mode_e;

  // Clamp a signed value to the range of a w-bit two's complement number.
  // Callers size-cast the result down to w bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                   input int unsigned        w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

endpackage

// File: rtl/sample_processor_moving_avg.sv
// Moving average over the last 2**AVG_LOG2 signed samples.
// Ring buffer plus running sum; avg reflects the sum after the last en.
module moving_avg
  import sample_proc_pkg::*;
#(
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic              sysclk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] avg
);

  localparam int unsigned DEPTH = 2 ** AVG_LOG2;
  localparam int unsigned SUM_W = DATA_W + AVG_LOG2;

  logic        [DATA_W-1:0]   ring_q [DEPTH];
  logic        [AVG_LOG2-1:0] wr_ptr;
  logic signed [SUM_W-1:0]    sum_q;
  logic signed [SUM_W-1:0]    sum_new;

  // New sum adds the incoming sample and drops the entry being overwritten.
  always_comb begin
    sum_new = sum_q
            + {{AVG_LOG2{x[DATA_W-1]}}, x}
            - {{AVG_LOG2{ring_q[wr_ptr][DATA_W-1]}}, ring_q[wr_ptr]};
  end

  // Ring buffer, wrapping write pointer and running sum.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        ring_q[i] <= '0;
      wr_ptr <= '0;
      sum_q  <= '0;
    end else if (en) begin
      ring_q[wr_ptr] <= x;
      wr_ptr         <= wr_ptr + 1'b1;
      sum_q          <= sum_new;
    end
  end

  // Arithmetic shift floors toward -inf; result always fits DATA_W bits.
  always_comb begin
    avg = DATA_W'(sum_q >>> AVG_LOG2);
  end

endmodule

// File: rtl/sample_processor.sv
// ADC-to-DAC sample processor: offset-binary in, pass/gain/average/invert,
// offset-binary out. Two-stage pipeline triggered by a data_valid rising edge.
// Optional macro SAMPLE_PROC_CLIP_EN adds a clip output flagging saturation.
module sample_processor
  import sample_proc_pkg::*;
#(
  parameter int unsigned DATA_W       = 10,
  parameter int unsigned ADC_OFFSET   = 2 ** (DATA_W - 1),
  parameter int unsigned DAC_OFFSET   = 2 ** (DATA_W - 1),
  parameter int unsigned AVG_LOG2     = 2,
  parameter int unsigned GAIN_SHIFT_W = 3
) (
  input  logic                    sysclk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    data_valid,
  input  logic [1:0]              mode,
  input  logic [GAIN_SHIFT_W-1:0] gain_shift,
  output logic [DATA_W-1:0]       data_out,
  output logic                    out_valid
`ifdef SAMPLE_PROC_CLIP_EN
  ,
  output logic                    clip
`endif
);

  localparam int unsigned GW = DATA_W + 2 ** GAIN_SHIFT_W;

  logic                    dv_d;
  logic                    enable;
  logic [DATA_W-1:0]       x_next;

  logic                    v1_q;
  logic signed [DATA_W-1:0] x_q;
  mode_e                   mode_q;
  logic [GAIN_SHIFT_W-1:0] gs_q;

  logic [DATA_W-1:0]       avg;
  logic signed [GW-1:0]    gain_wide;
  logic signed [DATA_W:0]  neg_wide;
  logic signed [DATA_W-1:0] y;

  // Rising-edge detect on the level data_valid; offset removal for stage 1.
  always_comb begin
    enable = data_valid & ~dv_d;
    x_next = data_in - DATA_W'(ADC_OFFSET);
  end

  // Averager is fed in stage 1 regardless of mode so mode switches see history.
  moving_avg #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .sysclk (sysclk),
    .rst    (rst),
    .en     (enable),
    .x      (x_next),
    .avg    (avg)
  );

  // Stage-2 operation select; widened intermediates keep saturation exact.
  always_comb begin
    gain_wide = {{(GW - DATA_W){x_q[DATA_W-1]}}, x_q} << gs_q;
    neg_wide  = -{x_q[DATA_W-1], x_q};
    case (mode_q)
      MODE_GAIN: y = DATA_W'(saturate(64'(gain_wide), DATA_W));
      MODE_INV:  y = DATA_W'(saturate(64'(neg_wide), DATA_W));
      MODE_AVG:  y = avg;
      default:   y = x_q;
    endcase
  end

  // Edge-detect history, stage-1 capture and stage-2 output registers.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      dv_d      <= 1'b0;
      v1_q      <= 1'b0;
      x_q       <= '0;
      mode_q    <= MODE_PASS;
      gs_q      <= '0;
      data_out  <= DATA_W'(DAC_OFFSET);
      out_valid <= 1'b0;
    end else begin
      dv_d      <= data_valid;
      v1_q      <= enable;
      out_valid <= v1_q;
      if (enable) begin
        x_q    <= x_next;
        mode_q <= mode_e'(mode);
        gs_q   <= gain_shift;
      end
      if (v1_q)
        data_out <= y + DATA_W'(DAC_OFFSET);
    end
  end

`ifdef SAMPLE_PROC_CLIP_EN
  logic sat;

  // Saturation happened when the clamped value differs from the wide result.
  always_comb begin
    case (mode_q)
      MODE_GAIN: sat = saturate(64'(gain_wide), DATA_W) != 64'(gain_wide);
      MODE_INV:  sat = saturate(64'(neg_wide), DATA_W) != 64'(neg_wide);
      default:   sat = 1'b0;
    endcase
  end

  // Clip pulses alongside out_valid only.
  always_ff @(posedge sysclk) begin
    if (rst)
      clip <= 1'b0;
    else
      clip <= v1_q & sat;
  end
`endif

endmodule

// File: tb/tb_sample_processor.sv
// Directed, table-driven bench for sample_processor (DATA_W=10, AVG_LOG2=2).
module tb_sample_processor;

  logic       sysclk = 1'b0;
  logic       rst;
  logic [9:0] data_in;
  logic       data_valid;
  logic [1:0] mode;
  logic [2:0] gain_shift;
  logic [9:0] data_out;
  logic       out_valid;
`ifdef SAMPLE_PROC_CLIP_EN
  logic       clip;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 sysclk = ~sysclk;

  sample_processor #(
    .DATA_W       (10),
    .AVG_LOG2     (2),
    .GAIN_SHIFT_W (3)
  ) dut (
    .sysclk     (sysclk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .mode       (mode),
    .gain_shift (gain_shift),
    .data_out   (data_out),
    .out_valid  (out_valid)
`ifdef SAMPLE_PROC_CLIP_EN
    ,
    .clip       (clip)
`endif
  );

  typedef struct {
    bit         rst_before;
    logic [1:0] mode;
    logic [2:0] gs;
    logic [9:0] din;
    logic [9:0] exp_out;
    bit         exp_clip;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    rst        = 1'b1;
    data_valid = 1'b0;
    @(posedge sysclk);
    @(posedge sysclk);
    @(negedge sysclk);
    rst = 1'b0;
  endtask

  // One isolated sample: checks latency, value and single-cycle pulse.
  task automatic send(input string name, input logic [1:0] m, input logic [2:0] g,
                      input logic [9:0] d, input logic [9:0] exp, input bit exp_clip);
    @(negedge sysclk);
    data_in    = d;
    mode       = m;
    gain_shift = g;
    data_valid = 1'b1;
    @(posedge sysclk); #1;
    check({name, " early_valid"}, 32'(out_valid), 32'd0);
    @(posedge sysclk); #1;
    check({name, " out_valid"}, 32'(out_valid), 32'd1);
    check({name, " data_out"}, 32'(data_out), 32'(exp));
`ifdef SAMPLE_PROC_CLIP_EN
    check({name, " clip"}, 32'(clip), 32'(exp_clip));
`else
    if (exp_clip) begin end
`endif
    data_valid = 1'b0;
    @(posedge sysclk); #1;
    check({name, " pulse_end"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int pulses;
    bit dv_pat;

    rst        = 1'b1;
    data_in    = '0;
    data_valid = 1'b0;
    mode       = 2'd0;
    gain_shift = 3'd0;

    vecs[0]  = '{0, 2'd0, 3'd0, 10'd700,  10'd700,  0};
    vecs[1]  = '{0, 2'd1, 3'd1, 10'd700,  10'd888,  0};
    vecs[2]  = '{0, 2'd1, 3'd1, 10'd900,  10'd1023, 1};
    vecs[3]  = '{0, 2'd1, 3'd3, 10'd400,  10'd0,    1};
    vecs[4]  = '{0, 2'd1, 3'd2, 10'd480,  10'd384,  0};
    vecs[5]  = '{0, 2'd1, 3'd0, 10'd700,  10'd700,  0};
    vecs[6]  = '{0, 2'd3, 3'd0, 10'd0,    10'd1023, 1};
    vecs[7]  = '{0, 2'd3, 3'd0, 10'd600,  10'd424,  0};
    vecs[8]  = '{0, 2'd3, 3'd0, 10'd1023, 10'd1,    0};
    vecs[9]  = '{1, 2'd2, 3'd0, 10'd612,  10'd537,  0};
    vecs[10] = '{0, 2'd2, 3'd0, 10'd612,  10'd562,  0};
    vecs[11] = '{0, 2'd2, 3'd0, 10'd612,  10'd587,  0};
    vecs[12] = '{0, 2'd2, 3'd0, 10'd612,  10'd612,  0};
    vecs[13] = '{1, 2'd2, 3'd0, 10'd511,  10'd511,  0};

    repeat (3) @(posedge sysclk);
    #1;
    check("reset data_out", 32'(data_out), 32'd512);
    check("reset out_valid", 32'(out_valid), 32'd0);
    @(negedge sysclk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      if (vecs[i].rst_before) do_reset();
      send($sformatf("vec%0d", i), vecs[i].mode, vecs[i].gs, vecs[i].din,
           vecs[i].exp_out, vecs[i].exp_clip);
    end

    // Held-high data_valid: two rising edges over the window -> two pulses.
    do_reset();
    mode    = 2'd0;
    data_in = 10'd700;
    pulses  = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge sysclk);
      data_valid = (i < 5) || (i >= 7 && i < 10);
      @(posedge sysclk); #1;
      if (out_valid) pulses++;
    end
    check("held_high pulses", 32'(pulses), 32'd2);

    // Edges two cycles apart with different data: no sample dropped.
    @(negedge sysclk);
    data_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sysclk);
      dv_pat     = (i == 0) || (i == 2);
      data_valid = dv_pat;
      data_in    = (i == 0) ? 10'd700 : 10'd300;
      @(posedge sysclk); #1;
      check($sformatf("b2b valid c%0d", i), 32'(out_valid),
            32'((i == 1) || (i == 3)));
      if (i == 1) check("b2b data0", 32'(data_out), 32'd700);
      if (i == 3) check("b2b data1", 32'(data_out), 32'd300);
    end

    // Reset while a sample sits in stage 1 aborts it and clears the averager.
    do_reset();
    @(negedge sysclk);
    mode       = 2'd2;
    data_in    = 10'd612;
    data_valid = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    rst = 1'b1;
    @(posedge sysclk); #1;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort data_out", 32'(data_out), 32'd512);
    @(negedge sysclk);
    rst        = 1'b0;
    data_valid = 1'b0;
    @(posedge sysclk); #1;
    check("abort after", 32'(out_valid), 32'd0);
    send("post_abort avg", 2'd2, 3'd0, 10'd612, 10'd537, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
